// File: rtl/knapsack_subset_scanner.sv
// Walks every item subset past the combinational knapsack checker and streams
// the accepted subsets out through a single-entry valid/ready slot.
module knapsack_subset_scanner #(
    parameter int unsigned N_ITEMS = 5,
    parameter int unsigned CNT_W   = N_ITEMS + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [N_ITEMS-1:0] cand,
    input  logic               cand_ok,
    output logic               sol_valid,
    input  logic               sol_ready,
    output logic [N_ITEMS-1:0] sol_data,
    output logic [CNT_W-1:0]   sol_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [N_ITEMS-1:0] CAND_LAST = '1;

    state_t             state, state_nx;
    logic [N_ITEMS-1:0] cand_nx;
    logic               sol_valid_nx;
    logic [N_ITEMS-1:0] sol_data_nx;
    logic [CNT_W-1:0]   sol_count_nx;
    logic               xfer;
    logic               stall;

    assign xfer  = sol_valid & sol_ready;
    assign stall = cand_ok & sol_valid & ~sol_ready;

    // Next-state and slot update
    always_comb begin
        state_nx     = state;
        cand_nx      = cand;
        sol_valid_nx = sol_valid;
        sol_data_nx  = sol_data;
        sol_count_nx = sol_count;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx     = ST_SCAN;
                    cand_nx      = '0;
                    sol_count_nx = '0;
                end
            end
            ST_SCAN: begin
                if (!stall) begin
                    if (cand_ok) begin
                        sol_data_nx  = cand;
                        sol_valid_nx = 1'b1;
                        sol_count_nx = sol_count + CNT_W'(1);
                    end else if (xfer) begin
                        sol_valid_nx = 1'b0;
                    end
                    // Skip DRAIN when the slot is already empty after the last candidate
                    if (cand == CAND_LAST) begin
                        state_nx = sol_valid_nx ? ST_DRAIN : ST_DONE;
                    end else begin
                        cand_nx = cand + N_ITEMS'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (!sol_valid || xfer) begin
                    sol_valid_nx = 1'b0;
                    state_nx     = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cand      <= '0;
            sol_valid <= 1'b0;
            sol_data  <= '0;
            sol_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            cand      <= cand_nx;
            sol_valid <= sol_valid_nx;
            sol_data  <= sol_data_nx;
            sol_count <= sol_count_nx;
            busy      <= (state_nx == ST_SCAN) || (state_nx == ST_DRAIN);
            done      <= (state_nx == ST_DONE);
        end
    end

endmodule
